z80_bus_ctrl: RTL and testbench

Parametrised Z80 bus controller placed between the T80-family CPU core and the system bus. It generates the CPU clock enable from a programmable divider, which provides turbo/normal speed selection. It inserts programmable wait states separately for memory and I/O cycles. It registers read data into the core, supplying the floating-bus value when idle and the IM2 vector during interrupt acknowledge, and it registers write data and drive enable toward the system bus.

---
 rtl/z80_bus_ctrl.sv | 120 ++++++++++++
 tb/tb_z80_bus_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_ctrl.sv
// Z80 bus controller: CPU clock-enable divider, memory/I/O wait-state insertion,
// and registered data paths between the T80 core and the system bus.
module z80_bus_ctrl #(
    parameter int             DW        = 8,
    parameter int             DIV_W     = 3,
    parameter int             WS_W      = 4,
    parameter logic [DW-1:0]  FLOAT_VAL = 8'hFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] cen_div,
    input  logic [WS_W-1:0]  mem_waits,
    input  logic [WS_W-1:0]  io_waits,
    input  logic             cpu_m1_n,
    input  logic             cpu_mreq_n,
    input  logic             cpu_iorq_n,
    input  logic             cpu_rd_n,
    input  logic             cpu_wr_n,
    input  logic             cpu_busak_n,
    input  logic [DW-1:0]    cpu_dout,
    input  logic             ext_wait_n,
    input  logic [DW-1:0]    di,
    input  logic [DW-1:0]    int_vector,
    output logic             cpu_cen,
    output logic             cpu_wait_n,
    output logic [DW-1:0]    cpu_di,
    output logic [DW-1:0]    dout,
    output logic             dout_oe,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [DIV_W-1:0] cnt;
    logic [1:0]       state;
    logic [WS_W-1:0]  wcnt;
    logic [WS_W-1:0]  wload;
    logic             rd_act;
    logic             wr_act;
    logic             inta;
    logic             strobe;

    assign rd_act = (!cpu_mreq_n || !cpu_iorq_n) && !cpu_rd_n;
    assign wr_act = (!cpu_mreq_n || !cpu_iorq_n) && !cpu_wr_n;
    assign inta   = !cpu_m1_n && !cpu_iorq_n;
    assign strobe = rd_act || wr_act || inta;
    assign wload  = !cpu_iorq_n ? io_waits : mem_waits;

    // The >= compare lets a shrinking divisor take effect without wrapping the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            cpu_cen <= 1'b0;
        end else if (cnt >= cen_div) begin
            cnt     <= '0;
            cpu_cen <= 1'b1;
        end else begin
            cnt     <= cnt + 1'b1;
            cpu_cen <= 1'b0;
        end
    end

    // Bus grant to another master aborts any cycle in progress, on any clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            wcnt  <= '0;
        end else if (!cpu_busak_n) begin
            state <= ST_IDLE;
        end else if (cpu_cen) begin
            case (state)
                ST_IDLE: begin
                    if (strobe) begin
                        wcnt  <= wload;
                        state <= (wload != '0) ? ST_WAIT : ST_HOLD;
                    end
                end
                ST_WAIT: begin
                    wcnt <= wcnt - 1'b1;
                    if (wcnt <= WS_W'(1))
                        state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!strobe)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_wait_n = ext_wait_n && (state != ST_WAIT);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_di <= FLOAT_VAL;
        end else if (inta) begin
            cpu_di <= int_vector;
        end else if (rd_act) begin
            cpu_di <= di;
        end else if (!(wr_act || !cpu_busak_n)) begin
            cpu_di <= FLOAT_VAL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout    <= '0;
            dout_oe <= 1'b0;
        end else begin
            dout_oe <= wr_act && cpu_busak_n;
            if (wr_act)
                dout <= cpu_dout;
        end
    end

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Self-checking bench for z80_bus_ctrl: directed scenarios plus randomized bus
// cycles judged by cycle-count and data-path rules.
module tb_z80_bus_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] cen_div;
    logic [3:0] mem_waits;
    logic [3:0] io_waits;
    logic       cpu_m1_n, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_busak_n;
    logic [7:0] cpu_dout;
    logic       ext_wait_n;
    logic [7:0] di;
    logic [7:0] int_vector;
    logic       cpu_cen;
    logic       cpu_wait_n;
    logic [7:0] cpu_di;
    logic [7:0] dout;
    logic       dout_oe;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] dout_exp = 8'h00;

    z80_bus_ctrl #(.DW(8), .DIV_W(3), .WS_W(4), .FLOAT_VAL(8'hFF)) dut (
        .clk(clk), .reset_n(reset_n), .cen_div(cen_div),
        .mem_waits(mem_waits), .io_waits(io_waits),
        .cpu_m1_n(cpu_m1_n), .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n),
        .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_busak_n(cpu_busak_n),
        .cpu_dout(cpu_dout), .ext_wait_n(ext_wait_n), .di(di), .int_vector(int_vector),
        .cpu_cen(cpu_cen), .cpu_wait_n(cpu_wait_n), .cpu_di(cpu_di),
        .dout(dout), .dout_oe(dout_oe), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_idle();
        cpu_m1_n = 1'b1; cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1;
        cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int t = 0;
        while (busy && t < limit) begin
            tick();
            t++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_idle: busy=%b after %0d clks, required 0", tag, busy, t);
        end
    endtask

    task automatic test_reset();
        set_idle();
        cpu_busak_n = 1'b1; ext_wait_n = 1'b1; cen_div = 3'd0;
        mem_waits = 4'd0; io_waits = 4'd0;
        cpu_dout = 8'h00; di = 8'h00; int_vector = 8'h00;
        reset_n = 1'b0;
        repeat (2) tick();
        n_checks++; if (cpu_cen !== 1'b0)   begin n_errors++; $display("FAIL reset_cen: got %b required 0", cpu_cen); end
        n_checks++; if (cpu_wait_n !== 1'b1) begin n_errors++; $display("FAIL reset_wait_n: got %b required 1", cpu_wait_n); end
        n_checks++; if (cpu_di !== 8'hFF)   begin n_errors++; $display("FAIL reset_cpu_di: got %h required ff", cpu_di); end
        n_checks++; if (dout !== 8'h00)     begin n_errors++; $display("FAIL reset_dout: got %h required 00", dout); end
        n_checks++; if (dout_oe !== 1'b0)   begin n_errors++; $display("FAIL reset_dout_oe: got %b required 0", dout_oe); end
        n_checks++; if (busy !== 1'b0)      begin n_errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        ext_wait_n = 1'b0;
        #1;
        n_checks++; if (cpu_wait_n !== 1'b0) begin n_errors++; $display("FAIL reset_wait_follow: got %b required 0", cpu_wait_n); end
        ext_wait_n = 1'b1;
    endtask

    task automatic test_divider();
        logic exp;
        int d;
        tick();
        cen_div = 3'd3;
        reset_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            exp = (k % 4 == 0);
            n_checks++;
            if (cpu_cen !== exp) begin n_errors++; $display("FAIL div3_cen clk%0d: got %b required %b", k, cpu_cen, exp); end
        end
        cen_div = 3'd1;
        for (int k = 12; k <= 17; k++) begin
            tick();
            exp = (k % 2 == 0);
            n_checks++;
            if (cpu_cen !== exp) begin n_errors++; $display("FAIL div_change_cen clk%0d: got %b required %b", k, cpu_cen, exp); end
        end
        repeat (4) begin
            d = int'($urandom_range(0, 7));
            reset_n = 1'b0;
            cen_div = 3'(d);
            tick();
            reset_n = 1'b1;
            for (int k = 1; k <= 2 * (d + 1) + 1; k++) begin
                tick();
                exp = (k % (d + 1) == 0);
                n_checks++;
                if (cpu_cen !== exp) begin n_errors++; $display("FAIL divrand_cen div%0d clk%0d: got %b required %b", d, k, cpu_cen, exp); end
            end
        end
    endtask

    // kind: 0 mem read, 1 mem write, 2 io read, 3 io write, 4 interrupt acknowledge
    task automatic run_cycle(input int kind, input bit m1, input int mw, input int iw,
                             input int d, input logic [7:0] data);
        int exp_w, low, cenlow, hlen;
        bit busy_seen, is_wr;
        logic [7:0] exp_di;
        cen_div = 3'(d); mem_waits = 4'(mw); io_waits = 4'(iw);
        repeat (4) tick();
        exp_w = (kind >= 2) ? iw : mw;
        is_wr = (kind == 1 || kind == 3);
        cpu_m1_n   = !(m1 || kind == 4);
        cpu_mreq_n = !(kind <= 1);
        cpu_iorq_n = !(kind >= 2);
        cpu_rd_n   = !(kind == 0 || kind == 2);
        cpu_wr_n   = !is_wr;
        cpu_dout   = is_wr ? data : 8'($urandom);
        int_vector = (kind == 4) ? data : 8'($urandom);
        di         = (kind == 0 || kind == 2) ? data : 8'($urandom);
        exp_di = is_wr ? 8'hFF : data;
        hlen = (exp_w + 3) * (d + 1);
        low = 0; cenlow = 0; busy_seen = 0;
        for (int i = 0; i < hlen; i++) begin
            tick();
            if (!cpu_wait_n) low++;
            if (cpu_cen && !cpu_wait_n) cenlow++;
            if (busy) busy_seen = 1;
            n_checks++;
            if (cpu_di !== exp_di) begin n_errors++; $display("FAIL cyc%0d_cpu_di clk%0d: got %h required %h", kind, i, cpu_di, exp_di); end
            n_checks++;
            if (dout_oe !== is_wr) begin n_errors++; $display("FAIL cyc%0d_dout_oe clk%0d: got %b required %b", kind, i, dout_oe, is_wr); end
            if (is_wr) begin
                n_checks++;
                if (dout !== data) begin n_errors++; $display("FAIL cyc%0d_dout clk%0d: got %h required %h", kind, i, dout, data); end
            end
        end
        if (is_wr) dout_exp = data;
        n_checks++; if (low != exp_w * (d + 1)) begin n_errors++; $display("FAIL cyc%0d_wait_clks: got %0d required %0d", kind, low, exp_w * (d + 1)); end
        n_checks++; if (cenlow != exp_w) begin n_errors++; $display("FAIL cyc%0d_wait_cens: got %0d required %0d", kind, cenlow, exp_w); end
        n_checks++; if (!busy_seen || busy !== 1'b1) begin n_errors++; $display("FAIL cyc%0d_busy: seen=%0d end=%b required 1/1", kind, busy_seen, busy); end
        set_idle();
        tick();
        n_checks++; if (cpu_di !== 8'hFF) begin n_errors++; $display("FAIL cyc%0d_end_cpu_di: got %h required ff", kind, cpu_di); end
        n_checks++; if (dout_oe !== 1'b0) begin n_errors++; $display("FAIL cyc%0d_end_dout_oe: got %b required 0", kind, dout_oe); end
        n_checks++; if (dout !== dout_exp) begin n_errors++; $display("FAIL cyc%0d_end_dout: got %h required %h", kind, dout, dout_exp); end
        wait_idle(2 * (d + 1) + 2, "cyc");
    endtask

    task automatic test_bus_cycles();
        run_cycle(0, 1'b0, 2, 0, 1, 8'h5A);
        run_cycle(3, 1'b0, 0, 3, 1, 8'hA5);
        run_cycle(4, 1'b0, 1, 2, 1, 8'hFF);
        run_cycle(4, 1'b0, 1, 1, 2, 8'h38);
        run_cycle(0, 1'b1, 0, 2, 1, 8'h3E);
    endtask

    task automatic test_ext_wait();
        cen_div = 3'd1; mem_waits = 4'd1; io_waits = 4'd0;
        repeat (4) tick();
        cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; di = 8'h77;
        repeat (10) tick();
        for (int i = 0; i < 5; i++) begin
            ext_wait_n = 1'b0;
            #1;
            n_checks++; if (cpu_wait_n !== 1'b0) begin n_errors++; $display("FAIL extwait_low clk%0d: got %b required 0", i, cpu_wait_n); end
            n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL extwait_busy clk%0d: got %b required 1", i, busy); end
            tick();
        end
        ext_wait_n = 1'b1;
        #1;
        n_checks++; if (cpu_wait_n !== 1'b1) begin n_errors++; $display("FAIL extwait_release: got %b required 1", cpu_wait_n); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL extwait_still_hold: got %b required 1", busy); end
        set_idle();
        wait_idle(6, "extwait");
    endtask

    task automatic test_busak();
        int t = 0;
        cen_div = 3'd1; mem_waits = 4'd5;
        repeat (4) tick();
        cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; di = 8'h5A;
        while (cpu_wait_n && t < 10) begin tick(); t++; end
        n_checks++; if (cpu_wait_n !== 1'b0) begin n_errors++; $display("FAIL busak_enter_wait: got %b required 0", cpu_wait_n); end
        tick();
        cpu_busak_n = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0)       begin n_errors++; $display("FAIL busak_busy: got %b required 0", busy); end
        n_checks++; if (cpu_wait_n !== 1'b1) begin n_errors++; $display("FAIL busak_wait_n: got %b required 1", cpu_wait_n); end
        n_checks++; if (dout_oe !== 1'b0)    begin n_errors++; $display("FAIL busak_dout_oe: got %b required 0", dout_oe); end
        set_idle();
        di = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (cpu_di !== 8'h5A) begin n_errors++; $display("FAIL busak_di_hold clk%0d: got %h required 5a", i, cpu_di); end
            n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL busak_stay_idle clk%0d: got %b required 0", i, busy); end
        end
        cpu_busak_n = 1'b1;
        tick();
        n_checks++; if (cpu_di !== 8'hFF) begin n_errors++; $display("FAIL busak_release_di: got %h required ff", cpu_di); end
    endtask

    task automatic test_random();
        int kind;
        repeat (20) begin
            kind = int'($urandom_range(0, 4));
            run_cycle(kind, (kind == 0) ? 1'($urandom) : 1'b0,
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                      int'($urandom_range(1, 3)), 8'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        cen_div = 3'd1; mem_waits = 4'd4;
        repeat (4) tick();
        cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0; cpu_dout = 8'hC3;
        while (cpu_wait_n && t < 10) begin tick(); t++; end
        tick();
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (cpu_cen !== 1'b0)    begin n_errors++; $display("FAIL rstmid_cen: got %b required 0", cpu_cen); end
        n_checks++; if (busy !== 1'b0)       begin n_errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
        n_checks++; if (cpu_wait_n !== 1'b1) begin n_errors++; $display("FAIL rstmid_wait_n: got %b required 1", cpu_wait_n); end
        n_checks++; if (dout !== 8'h00)      begin n_errors++; $display("FAIL rstmid_dout: got %h required 00", dout); end
        n_checks++; if (dout_oe !== 1'b0)    begin n_errors++; $display("FAIL rstmid_dout_oe: got %b required 0", dout_oe); end
        n_checks++; if (cpu_di !== 8'hFF)    begin n_errors++; $display("FAIL rstmid_cpu_di: got %h required ff", cpu_di); end
        set_idle();
        tick();
        reset_n = 1'b1;
        dout_exp = 8'h00;
        tick();
    endtask

    initial begin
        test_reset();
        test_divider();
        test_bus_cycles();
        test_ext_wait();
        test_busak();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
